// File: rtl/viterbi_channel_noise.sv
// Channel model for the Viterbi PRML datapath: registers the coded bit and
// inverts it in LFSR-triggered bursts, each followed by an error-free guard gap.
module viterbi_channel_noise #(
  parameter logic [15:0] SEED         = 16'hACE1,
  parameter int unsigned GUARD_CYCLES = 4,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable_i,
  input  logic             in_i,
  input  logic [8:0]       threshold_i,
  input  logic [3:0]       burst_len_i,
  output logic             out_o,
  output logic             flipped_o,
  output logic [CNT_W-1:0] err_count_o
);

  localparam int unsigned   GW       = (GUARD_CYCLES < 2) ? 1 : $clog2(GUARD_CYCLES + 1);
  localparam logic [GW-1:0] GUARD_LD = GW'(GUARD_CYCLES);
  localparam logic [15:0]   SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [15:0]   POLY     = 16'hB400;

  typedef enum logic [1:0] {IDLE, BURST, GUARD} state_e;

  state_e           state_q, state_d;
  logic [3:0]       bcnt_q, bcnt_d;
  logic [GW-1:0]    gcnt_q, gcnt_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             out_q, flipped_q;
  logic             trig, flip;

  // NOTE: every signal gets a default at the top of the block so no path
  // leaves it unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    gcnt_d  = gcnt_q;
    flip    = 1'b0;
    lfsr_d  = lfsr_q;
    trig    = enable_i && (burst_len_i != 4'd0) &&
              ({1'b0, lfsr_q[7:0]} < threshold_i);

    if (enable_i) begin
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? POLY : 16'h0000);
    end

    // Dropping enable abandons any burst or guard and restarts from IDLE.
    if (!enable_i) begin
      state_d = IDLE;
      bcnt_d  = '0;
      gcnt_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (trig) begin
            flip = 1'b1;
            if (burst_len_i == 4'd1) begin
              state_d = GUARD;
              gcnt_d  = GUARD_LD;
            end else begin
              state_d = BURST;
              bcnt_d  = burst_len_i - 4'd1;
            end
          end
        end
        BURST: begin
          flip   = 1'b1;
          bcnt_d = bcnt_q - 4'd1;
          if (bcnt_q == 4'd1) begin
            state_d = GUARD;
            gcnt_d  = GUARD_LD;
          end
        end
        GUARD: begin
          gcnt_d = gcnt_q - GW'(1);
          if (gcnt_q == GW'(1)) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    err_d = (err_q == {CNT_W{1'b1}}) ? err_q : err_q + CNT_W'(flip);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bcnt_q    <= '0;
      gcnt_q    <= '0;
      lfsr_q    <= SEED_EFF;
      err_q     <= '0;
      out_q     <= 1'b0;
      flipped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bcnt_q    <= bcnt_d;
      gcnt_q    <= gcnt_d;
      lfsr_q    <= lfsr_d;
      err_q     <= err_d;
      out_q     <= in_i ^ flip;
      flipped_q <= flip;
    end
  end

  assign out_o       = out_q;
  assign flipped_o   = flipped_q;
  assign err_count_o = err_q;

endmodule

// File: tb/tb_viterbi_channel_noise.sv
// Scoreboard bench for viterbi_channel_noise: directed stimulus pushes expected
// responses, a monitor pops and compares them one clock later.
module tb_viterbi_channel_noise;

  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Main instance: default parameters.
  logic        en = 1'b0, din = 1'b0;
  logic [8:0]  thr = '0;
  logic [3:0]  bl = '0;
  logic        dout, flipped;
  logic [15:0] errc;

  // Saturation instance: CNT_W=4, GUARD_CYCLES=1.
  logic        en2 = 1'b0, din2 = 1'b0;
  logic [8:0]  thr2 = 9'd256;
  logic [3:0]  bl2 = 4'd15;
  logic        dout2, flipped2;
  logic [3:0]  errc2;

  viterbi_channel_noise #(.SEED(SEED), .GUARD_CYCLES(4), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .enable_i(en), .in_i(din), .threshold_i(thr),
    .burst_len_i(bl), .out_o(dout), .flipped_o(flipped), .err_count_o(errc)
  );

  viterbi_channel_noise #(.SEED(SEED), .GUARD_CYCLES(1), .CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .enable_i(en2), .in_i(din2), .threshold_i(thr2),
    .burst_len_i(bl2), .out_o(dout2), .flipped_o(flipped2), .err_count_o(errc2)
  );

  typedef struct {
    bit          sat;
    logic        out;
    logic        flp;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  logic [15:0] lfsr_m;
  logic [15:0] err_m;
  logic [3:0]  err2_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Monitor: outputs are sampled 1 time unit after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        if (e.sat) begin
          check("sat_out", dout2, e.out);
          check("sat_flipped", flipped2, e.flp);
          check("sat_err_count", errc2, e.cnt);
        end else begin
          check("out", dout, e.out);
          check("flipped", flipped, e.flp);
          check("err_count", errc, e.cnt);
        end
      end
    end
  end

  // One main-instance cycle: f is the hand-derived flip for this input cycle.
  task automatic step(input logic e, input logic i, input logic [8:0] t,
                      input logic [3:0] b, input logic f);
    en = e; din = i; thr = t; bl = b;
    if (f && err_m != 16'hFFFF) err_m = err_m + 16'd1;
    sb.push_back('{sat: 1'b0, out: i ^ f, flp: f, cnt: err_m});
    if (e) lfsr_m = lfsr_next(lfsr_m);
    @(posedge clk);
    #2;
    check("lfsr", u_dut.lfsr_q, lfsr_m);
  endtask

  task automatic check_reset_state();
    check("rst_out", dout, 1'b0);
    check("rst_flipped", flipped, 1'b0);
    check("rst_err_count", errc, 16'd0);
    check("rst_lfsr", u_dut.lfsr_q, SEED);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] t2_pat [10];
    logic [8:0] tb_thr;

    // Reset state.
    #12;
    check_reset_state();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    lfsr_m = SEED;
    err_m = '0;
    err2_m = '0;

    // T1: threshold 0 -> clean registered pass-through.
    foreach (t2_pat[k]) t2_pat[k] = '0;
    step(1, 1, 9'd0, 4'd3, 0);
    step(1, 0, 9'd0, 4'd3, 0);
    step(1, 1, 9'd0, 4'd3, 0);
    step(1, 1, 9'd0, 4'd3, 0);
    step(1, 0, 9'd0, 4'd3, 0);

    // T3: burst_len 0 disables injection even at threshold 256.
    step(1, 1, 9'd256, 4'd0, 0);
    step(1, 0, 9'd256, 4'd0, 0);
    step(1, 1, 9'd256, 4'd0, 0);
    step(1, 0, 9'd256, 4'd0, 0);

    // T2: 3-bit bursts separated by 4 guard cycles.
    t2_pat = '{2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1};
    foreach (t2_pat[k]) step(1, 0, 9'd256, 4'd3, t2_pat[k][0]);
    check("t2_err_after_10", errc, 16'd6);
    for (int k = 0; k < 4; k++) step(1, 0, 9'd0, 4'd3, 0);

    // Threshold boundary: lfsr[7:0] < thr is strict.
    tb_thr = {1'b0, lfsr_m[7:0]};
    step(1, 1, tb_thr, 4'd1, 0);
    tb_thr = {1'b0, lfsr_m[7:0]} + 9'd1;
    step(1, 1, tb_thr, 4'd1, 1);
    for (int k = 0; k < 4; k++) step(1, 1, 9'd256, 4'd1, 0);

    // T4: reset after the second flipped bit of a burst.
    step(1, 0, 9'd256, 4'd3, 1);
    step(1, 0, 9'd256, 4'd3, 1);
    rst_n = 1'b0;
    #1;
    check_reset_state();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    lfsr_m = SEED;
    err_m = '0;
    step(1, 0, 9'd256, 4'd3, 1);
    step(1, 0, 9'd256, 4'd3, 1);
    step(1, 0, 9'd256, 4'd3, 1);
    for (int k = 0; k < 4; k++) step(1, 0, 9'd256, 4'd3, 0);

    // T5: enable drop mid-burst, LFSR held, fresh burst on re-enable.
    step(1, 0, 9'd256, 4'd3, 1);
    step(1, 0, 9'd256, 4'd3, 1);
    step(0, 1, 9'd256, 4'd3, 0);
    step(0, 0, 9'd256, 4'd3, 0);
    step(1, 0, 9'd256, 4'd3, 1);
    step(1, 0, 9'd0, 4'd1, 1);    // mid-burst changes are ignored
    step(1, 1, 9'd0, 4'd1, 1);
    for (int k = 0; k < 4; k++) step(1, 1, 9'd256, 4'd3, 0);
    en = 1'b0;

    // T6: 4-bit counter saturates at 15; out ^ flipped recovers the input.
    en2 = 1'b1;
    for (int k = 0; k < 40; k++) begin
      logic f2;
      logic b2;
      b2 = 1'($urandom_range(0, 1));
      f2 = ((k % 16) != 15);
      din2 = b2;
      if (f2 && err2_m != 4'hF) err2_m = err2_m + 4'd1;
      sb.push_back('{sat: 1'b1, out: b2 ^ f2, flp: f2, cnt: {12'd0, err2_m}});
      @(posedge clk);
      #2;
    end
    check("t6_saturated", errc2, 4'hF);
    en2 = 1'b0;

    @(posedge clk);
    #2;
    check("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
